// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core (C) and a DMA/debug master (D)
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_LAT   = 1,
  parameter int CORE_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_wr,
  input  logic [3:0]    c_mask,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  output logic          core_stall,
  input  logic          d_valid,
  input  logic          d_wr,
  input  logic [3:0]    d_mask,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_cs,
  output logic          m_wr,
  output logic [3:0]    m_mask,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          last_dma_q, own_dma_q, wr_q;
  logic [3:0]    mask_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, c_rdata_q, d_rdata_q;
  logic          start, gnt_dma;
  // arbitration and port-side strobes decoded from the FSM state
  always_comb begin
    start      = (state_q == IDLE) & (c_req | d_valid);
    gnt_dma    = d_valid & (~c_req | ((CORE_PRIO == 0) & ~last_dma_q));
    d_ready    = start & gnt_dma;
    m_cs       = state_q == BUSY;
    m_wr       = m_cs & wr_q & (cnt_q == LAT);
    c_ack      = (state_q == DONE) & ~own_dma_q;
    d_rvalid   = (state_q == DONE) & own_dma_q;
    core_stall = c_req & ~c_ack;
    m_mask     = mask_q;
    m_addr     = addr_q;
    m_wdata    = wdata_q;
    c_rdata    = c_rdata_q;
    d_rdata    = d_rdata_q;
  end
  // access sequencer: latch winner, hold chip select MEM_LAT cycles, then complete
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_dma_q <= 1'b1;
      own_dma_q  <= 1'b0;
      wr_q       <= 1'b0;
      mask_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          own_dma_q <= gnt_dma;
          wr_q      <= gnt_dma ? d_wr : c_wr;
          mask_q    <= gnt_dma ? d_mask : c_mask;
          addr_q    <= gnt_dma ? d_addr : c_addr;
          wdata_q   <= gnt_dma ? d_wdata : c_wdata;
          cnt_q     <= LAT;
          state_q   <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (own_dma_q) d_rdata_q <= m_rdata;
            else c_rdata_q <= m_rdata;
            state_q <= DONE;
          end
        end
        DONE: begin
          last_dma_q <= own_dma_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of a round-robin MEM_LAT=2 arbiter and a core-priority MEM_LAT=3 arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic c_req [2], c_wr [2], c_ack [2], core_stall [2];
  logic d_valid [2], d_wr [2], d_ready [2], d_rvalid [2];
  logic m_cs [2], m_wr [2];
  logic [3:0] c_mask [2], d_mask [2], m_mask [2];
  logic [31:0] c_addr [2], c_wdata [2], c_rdata [2];
  logic [31:0] d_addr [2], d_wdata [2], d_rdata [2];
  logic [31:0] m_addr [2], m_wdata [2], m_rdata [2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    dmem_arbiter #(.MEM_LAT(g ? 3 : 2), .CORE_PRIO(g)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req[g]), .c_wr(c_wr[g]), .c_mask(c_mask[g]), .c_addr(c_addr[g]),
      .c_wdata(c_wdata[g]), .c_rdata(c_rdata[g]), .c_ack(c_ack[g]), .core_stall(core_stall[g]),
      .d_valid(d_valid[g]), .d_wr(d_wr[g]), .d_mask(d_mask[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_ready(d_ready[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .m_cs(m_cs[g]), .m_wr(m_wr[g]), .m_mask(m_mask[g]), .m_addr(m_addr[g]),
      .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g])
    );
    assign m_rdata[g] = mem(m_addr[g]);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(negedge clk);
    #2;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      c_req[k] = 0; c_wr[k] = 0; c_mask[k] = 0; c_addr[k] = 0; c_wdata[k] = 0;
      d_valid[k] = 0; d_wr[k] = 0; d_mask[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
    end
    nxt;
    nxt;
    for (int k = 0; k < 2; k++) begin
      chk("rst_m_cs", m_cs[k], 0);
      chk("rst_c_ack", c_ack[k], 0);
      chk("rst_d_rvalid", d_rvalid[k], 0);
      chk("rst_m_addr", m_addr[k], 0);
      chk("rst_c_rdata", c_rdata[k], 0);
    end
    rst = 1;
    nxt;
    c_req[0] = 1; c_addr[0] = 32'h44; d_valid[0] = 1; d_addr[0] = 32'h100;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_d_ready", d_ready[0], 32'(i % 2));
      nxt;
      chk("rr_m_addr", m_addr[0], (i % 2) ? 32'h100 : 32'h44);
      nxt;
      nxt;
      chk("rr_c_ack", c_ack[0], 32'(1 - i % 2));
      chk("rr_d_rvalid", d_rvalid[0], 32'(i % 2));
      if (i % 2) chk("rr_d_rdata", d_rdata[0], 32'h5A5A0100);
      else chk("rr_c_rdata", c_rdata[0], 32'h5A5A0044);
      if (i == 3) begin c_req[0] = 0; d_valid[0] = 0; end
      nxt;
    end
    chk("rr_idle_cs", m_cs[0], 0);
    c_req[0] = 1; c_addr[0] = 32'h40;
    #1;
    chk("rd_stall0", core_stall[0], 1);
    chk("rd_cs0", m_cs[0], 0);
    nxt;
    chk("rd_cs1", m_cs[0], 1);
    chk("rd_addr1", m_addr[0], 32'h40);
    chk("rd_stall1", core_stall[0], 1);
    nxt;
    chk("rd_cs2", m_cs[0], 1);
    chk("rd_stall2", core_stall[0], 1);
    nxt;
    chk("rd_ack3", c_ack[0], 1);
    chk("rd_stall3", core_stall[0], 0);
    chk("rd_cs3", m_cs[0], 0);
    chk("rd_rdata3", c_rdata[0], 32'hDEADBEEF);
    c_req[0] = 0;
    nxt;
    chk("rd_ack4", c_ack[0], 0);
    chk("rd_hold4", c_rdata[0], 32'hDEADBEEF);
    c_req[1] = 1; c_wr[1] = 1; c_mask[1] = 4'b0011; c_wdata[1] = 32'h1234ABCD; c_addr[1] = 32'h80;
    #1;
    chk("wr_cs0", m_cs[1], 0);
    nxt;
    chk("wr_cs1", m_cs[1], 1);
    chk("wr_wr1", m_wr[1], 1);
    chk("wr_mask1", m_mask[1], 4'b0011);
    chk("wr_wdata1", m_wdata[1], 32'h1234ABCD);
    nxt;
    chk("wr_cs2", m_cs[1], 1);
    chk("wr_wr2", m_wr[1], 0);
    nxt;
    chk("wr_cs3", m_cs[1], 1);
    chk("wr_wr3", m_wr[1], 0);
    nxt;
    chk("wr_ack4", c_ack[1], 1);
    chk("wr_cs4", m_cs[1], 0);
    c_req[1] = 0; c_wr[1] = 0;
    nxt;
    chk("wr_ack5", c_ack[1], 0);
    c_req[1] = 1; c_addr[1] = 32'h44; d_valid[1] = 1; d_addr[1] = 32'h200;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fp_d_ready", d_ready[1], 0);
      nxt;
      nxt;
      nxt;
      nxt;
      chk("fp_c_ack", c_ack[1], 1);
      if (i == 2) c_req[1] = 0;
      nxt;
    end
    chk("fp_d_ready_free", d_ready[1], 1);
    nxt;
    chk("fp_cs1", m_cs[1], 1);
    chk("fp_addr1", m_addr[1], 32'h200);
    d_valid[1] = 0; d_addr[1] = 32'h300;
    nxt;
    chk("fp_addr2", m_addr[1], 32'h200);
    nxt;
    nxt;
    chk("fp_d_rvalid", d_rvalid[1], 1);
    chk("fp_d_rdata", d_rdata[1], 32'h5A5A0200);
    nxt;
    chk("fp_d_rvalid_end", d_rvalid[1], 0);
    c_req[0] = 1; c_wr[0] = 1; c_addr[0] = 32'h48;
    nxt;
    chk("rb_wr1", m_wr[0], 1);
    #1 rst = 0;
    #1;
    chk("rb_cs", m_cs[0], 0);
    chk("rb_wr", m_wr[0], 0);
    chk("rb_ack", c_ack[0], 0);
    chk("rb_d_ready", d_ready[0], 0);
    chk("rb_d_rvalid", d_rvalid[0], 0);
    chk("rb_c_rdata", c_rdata[0], 0);
    chk("rb_d_rdata1", d_rdata[1], 0);
    c_wr[0] = 0;
    nxt;
    rst = 1;
    #1;
    chk("rb_stall0", core_stall[0], 1);
    nxt;
    nxt;
    chk("rb_ack2", c_ack[0], 0);
    nxt;
    chk("rb_ack3", c_ack[0], 1);
    chk("rb_rdata3", c_rdata[0], 32'h5A5A0048);
    c_req[0] = 0;
    nxt;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
